// File: rtl/regbank_wr_arbiter.sv
// Register-bank write-port arbiter: WB writes vs. buffered multiply/divide results,
// with a busy scoreboard that lets decode stall on pending long-latency destinations.
module regbank_wr_arbiter #(
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_valid,
  input  logic [4:0]    wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic          wb_stall,
  input  logic          lu_issue,
  input  logic [4:0]    lu_issue_rd,
  output logic          lu_issue_ready,
  input  logic          lu_valid,
  input  logic [4:0]    lu_rd,
  input  logic [DW-1:0] lu_data,
  output logic          lu_ready,
  input  logic [4:0]    dec_rs,
  input  logic [4:0]    dec_rt,
  output logic          dec_stall,
  output logic [31:0]   busy_mask,
  output logic          RegWrite,
  output logic [4:0]    rd,
  output logic [DW-1:0] wr_data
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [4:0]    r_fifo_rd   [FIFO_DEPTH];
  logic [DW-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_busy;

  logic          w_full;
  logic          w_empty;
  logic [31:0]   w_busy;
  logic          w_wb_req;
  logic          w_wb_take;
  logic          w_pop;
  logic          w_push;
  logic          w_issue_set;
  logic [4:0]    w_head_rd;
  logic [DW-1:0] w_head_data;
  logic [31:0]   w_busy_nxt;

  // While rst_n is low the combinational outputs already reflect the cleared state.
  assign w_full      = rst_n && (r_count == CW'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_busy      = rst_n ? r_busy : 32'd0;
  assign w_head_rd   = r_fifo_rd[r_rptr];
  assign w_head_data = r_fifo_data[r_rptr];

  assign w_wb_req    = wb_valid && (wb_rd != 5'd0);
  assign w_wb_take   = w_wb_req && !w_full;
  assign w_pop       = !w_empty && (w_full || !w_wb_req);
  assign w_push      = lu_valid && !w_full && (lu_rd != 5'd0);

  assign lu_ready       = !w_full;
  assign wb_stall       = w_wb_req && w_full;
  assign lu_issue_ready = !w_busy[lu_issue_rd] || (lu_issue_rd == 5'd0);
  assign w_issue_set    = lu_issue && lu_issue_ready && (lu_issue_rd != 5'd0);
  assign busy_mask      = w_busy;
  assign dec_stall      = ((dec_rs != 5'd0) && w_busy[dec_rs]) ||
                          ((dec_rt != 5'd0) && w_busy[dec_rt]);

  // A busy bit being set is never the one being cleared: its issue is blocked while busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop) w_busy_nxt[w_head_rd] = 1'b0;
    if (w_issue_set) w_busy_nxt[lu_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_busy  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= lu_rd;
      r_fifo_data[r_wptr] <= lu_data;
    end
  end

  // Bank write stage: rd/wr_data hold when nothing is launched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RegWrite <= 1'b0;
      rd       <= 5'd0;
      wr_data  <= '0;
    end else if (w_wb_take) begin
      RegWrite <= 1'b1;
      rd       <= wb_rd;
      wr_data  <= wb_data;
    end else if (w_pop) begin
      RegWrite <= 1'b1;
      rd       <= w_head_rd;
      wr_data  <= w_head_data;
    end else begin
      RegWrite <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Directed bench for regbank_wr_arbiter: a write scoreboard checks every bank write
// in order, directed checks cover handshakes, scoreboard, r0 and reset behaviour.
module tb_regbank_wr_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic [DW-1:0] wb_data;
  logic          wb_stall;
  logic          lu_issue;
  logic [4:0]    lu_issue_rd;
  logic          lu_issue_ready;
  logic          lu_valid;
  logic [4:0]    lu_rd;
  logic [DW-1:0] lu_data;
  logic          lu_ready;
  logic [4:0]    dec_rs;
  logic [4:0]    dec_rt;
  logic          dec_stall;
  logic [31:0]   busy_mask;
  logic          RegWrite;
  logic [4:0]    rd;
  logic [DW-1:0] wr_data;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [36:0] exp_q[$];

  regbank_wr_arbiter #(.DW(DW), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
    .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd), .lu_issue_ready(lu_issue_ready),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_stall(dec_stall), .busy_mask(busy_mask),
    .RegWrite(RegWrite), .rd(rd), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every bank write is matched in order against the expected-write queue.
  always @(negedge clk) begin
    if (RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {27'd0, rd, wr_data}, 64'h0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("write_rd_data", {27'd0, rd, wr_data}, {27'd0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    lu_issue = 0; lu_issue_rd = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
  endtask

  initial begin
    rst_n = 0; dec_rs = 0; dec_rt = 0;
    idle_inputs();
    tick(); tick();
    rst_n = 1;
    #1;
    chk("rst_regwrite", {63'd0, RegWrite}, 64'd0);
    chk("rst_busy", {32'd0, busy_mask}, 64'd0);
    chk("rst_lu_ready", {63'd0, lu_ready}, 64'd1);
    chk("rst_dec_stall", {63'd0, dec_stall}, 64'd0);

    // WB path
    wb_valid = 1; wb_rd = 5; wb_data = 32'hDEAD_BEEF;
    exp_q.push_back({5'd5, 32'hDEAD_BEEF});
    tick();
    idle_inputs();
    chk("wb_regwrite", {63'd0, RegWrite}, 64'd1);
    chk("wb_rd", {59'd0, rd}, 64'd5);
    chk("wb_data", {32'd0, wr_data}, 64'hDEAD_BEEF);
    tick();
    chk("wb_regwrite_off", {63'd0, RegWrite}, 64'd0);

    // LU scoreboard
    lu_issue = 1; lu_issue_rd = 7;
    #1;
    chk("issue_ready_free", {63'd0, lu_issue_ready}, 64'd1);
    tick();
    lu_issue = 0;
    dec_rs = 7;
    #1;
    chk("busy_after_issue", {32'd0, busy_mask}, 64'h80);
    chk("dec_stall_rs", {63'd0, dec_stall}, 64'd1);
    dec_rs = 0; dec_rt = 7;
    #1;
    chk("dec_stall_rt", {63'd0, dec_stall}, 64'd1);
    dec_rt = 0; dec_rs = 7;
    lu_issue = 1; lu_issue_rd = 7;
    #1;
    chk("issue_ready_busy", {63'd0, lu_issue_ready}, 64'd0);
    lu_issue_rd = 6;
    #1;
    chk("issue_ready_other", {63'd0, lu_issue_ready}, 64'd1);
    lu_issue = 0;
    lu_valid = 1; lu_rd = 7; lu_data = 32'h1234;
    #1;
    chk("lu_ready_empty", {63'd0, lu_ready}, 64'd1);
    exp_q.push_back({5'd7, 32'h1234});
    tick();
    idle_inputs();
    chk("lu_not_yet", {63'd0, RegWrite}, 64'd0);
    chk("busy_still", {63'd0, busy_mask[7]}, 64'd1);
    tick();
    chk("lu_launch", {63'd0, RegWrite}, 64'd1);
    chk("lu_launch_rd", {59'd0, rd}, 64'd7);
    chk("busy_cleared", {32'd0, busy_mask}, 64'd0);
    chk("dec_stall_cleared", {63'd0, dec_stall}, 64'd0);
    dec_rs = 0;
    tick();
    chk("lu_launch_off", {63'd0, RegWrite}, 64'd0);

    // Contention: WB r1..r4 against LU r8, r9
    wb_valid = 1; wb_rd = 1; wb_data = 32'h11;
    lu_valid = 1; lu_rd = 8; lu_data = 32'h88;
    exp_q.push_back({5'd1, 32'h11});
    exp_q.push_back({5'd2, 32'h22});
    exp_q.push_back({5'd8, 32'h88});
    exp_q.push_back({5'd3, 32'h33});
    exp_q.push_back({5'd4, 32'h44});
    exp_q.push_back({5'd9, 32'h99});
    tick();
    wb_rd = 2; wb_data = 32'h22;
    lu_rd = 9; lu_data = 32'h99;
    #1;
    chk("ct_wb_stall_c1", {63'd0, wb_stall}, 64'd0);
    tick();
    lu_valid = 0;
    wb_rd = 3; wb_data = 32'h33;
    #1;
    chk("ct_full_wb_stall", {63'd0, wb_stall}, 64'd1);
    chk("ct_full_lu_ready", {63'd0, lu_ready}, 64'd0);
    tick();
    chk("ct_r8_rd", {59'd0, rd}, 64'd8);
    chk("ct_wb_resume", {63'd0, wb_stall}, 64'd0);
    chk("ct_lu_ready_back", {63'd0, lu_ready}, 64'd1);
    tick();
    wb_rd = 4; wb_data = 32'h44;
    chk("ct_r3_rd", {59'd0, rd}, 64'd3);
    tick();
    wb_valid = 0;
    chk("ct_r4_rd", {59'd0, rd}, 64'd4);
    tick();
    chk("ct_r9_rd", {59'd0, rd}, 64'd9);
    tick();
    chk("ct_drained", {63'd0, RegWrite}, 64'd0);

    // r0 handling
    wb_valid = 1; wb_rd = 0; wb_data = 32'hBAD0;
    lu_issue = 1; lu_issue_rd = 0;
    lu_valid = 1; lu_rd = 0; lu_data = 32'hBAD1;
    #1;
    chk("r0_wb_stall", {63'd0, wb_stall}, 64'd0);
    chk("r0_lu_ready", {63'd0, lu_ready}, 64'd1);
    chk("r0_issue_ready", {63'd0, lu_issue_ready}, 64'd1);
    tick();
    idle_inputs();
    chk("r0_no_write", {63'd0, RegWrite}, 64'd0);
    chk("r0_busy", {32'd0, busy_mask}, 64'd0);
    tick();
    chk("r0_no_lu_write", {63'd0, RegWrite}, 64'd0);

    // Wrap-around: six back-to-back results
    for (int k = 0; k < 6; k++) begin
      lu_valid = 1; lu_rd = 5'(10 + k); lu_data = 32'hA0 + k;
      exp_q.push_back({5'(10 + k), 32'hA0 + k});
      #1;
      chk("wrap_lu_ready", {63'd0, lu_ready}, 64'd1);
      tick();
      if (k > 0) chk("wrap_rd", {59'd0, rd}, 64'(10 + k - 1));
    end
    idle_inputs();
    tick();
    chk("wrap_last_rd", {59'd0, rd}, 64'd15);
    tick();
    chk("wrap_empty", {63'd0, RegWrite}, 64'd0);

    // Reset with two entries pending and busy 0x30
    lu_issue = 1; lu_issue_rd = 4;
    tick();
    lu_issue_rd = 5;
    tick();
    lu_issue = 0;
    chk("pre_rst_busy", {32'd0, busy_mask}, 64'h30);
    wb_valid = 1; wb_rd = 1; wb_data = 32'h1111;
    lu_valid = 1; lu_rd = 4; lu_data = 32'h4444;
    exp_q.push_back({5'd1, 32'h1111});
    exp_q.push_back({5'd2, 32'h2222});
    tick();
    wb_rd = 2; wb_data = 32'h2222;
    lu_rd = 5; lu_data = 32'h5555;
    tick();
    idle_inputs();
    #1;
    chk("pre_rst_full", {63'd0, lu_ready}, 64'd0);
    rst_n = 0;
    #1;
    chk("in_rst_lu_ready", {63'd0, lu_ready}, 64'd1);
    chk("in_rst_issue_ready", {63'd0, lu_issue_ready}, 64'd1);
    tick();
    chk("post_rst_regwrite", {63'd0, RegWrite}, 64'd0);
    chk("post_rst_busy", {32'd0, busy_mask}, 64'd0);
    chk("post_rst_lu_ready", {63'd0, lu_ready}, 64'd1);
    chk("post_rst_rd", {59'd0, rd}, 64'd0);
    rst_n = 1;
    for (int k = 0; k < 4; k++) tick();
    chk("post_rst_no_write", {63'd0, RegWrite}, 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regbank_wr_arbiter.md
# regbank_wr_arbiter

Write-port controller for the 32x32 register bank. The bank has one combinational write port (`rd`, `wr_data`, `RegWrite`), and two sources need it: the pipeline write-back stage and the long-latency multiply/divide unit (LU). This block arbitrates the port, buffers LU results in a small FIFO, and keeps a busy scoreboard of registers awaiting LU results so decode can stall on RAW hazards. It sits between WB/LU and the register bank; decode reads `dec_stall`.

## Interface
- `DW`, 32, data width
- `FIFO_DEPTH`, 2, LU result buffer entries (power of two, ≥2)
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `wb_valid`  in  1  WB write request
- `wb_rd`  in  5  WB destination
- `wb_data`  in  DW  WB data
- `wb_stall`  out  1  WB request not taken this cycle; WB holds its request
- `lu_issue`  in  1  LU op issued; reserve destination
- `lu_issue_rd`  in  5  destination of issued op
- `lu_issue_ready`  out  1  issue accepted this cycle
- `lu_valid`  in  1  LU result valid
- `lu_rd`  in  5  result destination
- `lu_data`  in  DW  result data
- `lu_ready`  out  1  result accepted this cycle
- `dec_rs`, `dec_rt`  in  5 each  decode source registers
- `dec_stall`  out  1  a decode source is busy
- `busy_mask`  out  32  scoreboard; bit n set means rn awaits an LU result
- `RegWrite`  out  1  register-bank write enable (registered)
- `rd`  out  5  register-bank write address (registered)
- `wr_data`  out  DW  register-bank write data (registered)

## Operation
- **Handshakes:**
  - LU results transfer on `lu_valid && lu_ready`. `lu_ready = !fifo_full`; a pop in the same cycle does not raise it.
  - An issue is accepted on `lu_issue && lu_issue_ready`. `lu_issue_ready = !busy_mask[lu_issue_rd] || lu_issue_rd==0`.
- **Arbitration:** one bank write per cycle.
  - FIFO not full: a WB request with `wb_rd != 0` wins. Otherwise the FIFO head is popped if non-empty.
  - FIFO full: the FIFO head wins, and `wb_stall = wb_valid && wb_rd != 0`. This is the starvation guard.
  - `wb_stall` is combinational and is 0 when the WB request is taken.
- **r0:** writes to r0 are never launched.
  - A WB request with rd=0 is consumed silently (`wb_stall` = 0).
  - An LU result with rd=0 is accepted and dropped, not pushed.
  - Issues with rd=0 never set a busy bit.
- **Scoreboard:**
  - An accepted issue with rd≠0 sets `busy_mask[rd]` at the clock edge.
  - A busy bit clears at the edge where the FIFO entry for that rd is launched to the port outputs.
  - Set and clear of the same bit in one cycle cannot occur, because the issue is blocked while the bit is busy.
- **Decode stall:** `dec_stall = (dec_rs!=0 && busy_mask[dec_rs]) || (dec_rt!=0 && busy_mask[dec_rt])`, combinational.
- **WAW:** a WB write to a busy register is launched normally; the scoreboard is unchanged, and the later LU write wins.
- **FIFO:**
  - In-order circular buffer with wrapping read/write pointers and an occupancy count of 0..FIFO_DEPTH.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- **Reset** (`rst_n`=0 at an edge), including mid-operation:
  - FIFO emptied (contents discarded), `busy_mask` = 0.
  - `RegWrite` = 0, `rd` = 0, `wr_data` = 0; this holds for the whole cycle following the reset edge.
  - Combinational outputs during reset follow the cleared state: `lu_ready` = 1, `lu_issue_ready` = 1, `dec_stall` = 0.

## Timing
- Registered outputs (`RegWrite`, `rd`, `wr_data`) update on the edge where arbitration selects a source. When nothing is selected, `RegWrite` = 0 and `rd`/`wr_data` hold their values.
- WB latency: request sampled at edge E → bank write visible in cycle E+1.
- LU latency: accepted at edge E0 → earliest launch at E1, so 2 cycles to the bank when no WB competes.
- `busy_mask` clears at the same edge as the launch, so `dec_stall` drops in the cycle the bank holds the new value (bank write is combinational).
- All ready/stall outputs are combinational from current state and inputs; there are no combinational paths from `lu_valid` to `lu_ready`.

## Test plan
- **Reset:** assert `rst_n`=0 with FIFO holding 2 entries and `busy_mask`=0x0000_0030. Required: next cycle `RegWrite`=0, `busy_mask`=0, `lu_ready`=1, no write from the old entries ever.
- **WB path:** `wb_valid` with rd=5, data 0xDEAD_BEEF for one cycle. Required: the following cycle `RegWrite`=1, `rd`=5, `wr_data`=0xDEAD_BEEF, then `RegWrite`=0.
- **LU scoreboard:**
  - Issue rd=7 → `busy_mask[7]`=1; `dec_rs`=7 gives `dec_stall`=1; a second issue to rd=7 sees `lu_issue_ready`=0.
  - Result rd=7, 0x1234 → launched 2 cycles after acceptance; `busy_mask[7]` and `dec_stall` clear in that cycle.
- **Contention and full FIFO:** continuous WB writes to r1..r4 while the LU pushes to r8, r9.
  - WB wins until the FIFO is full; then `wb_stall`=1 and r8 is written.
  - Next cycle the FIFO is not full: WB resumes, and r9 drains when WB is idle.
  - `lu_ready`=0 while full.
- **r0 handling:** WB rd=0, LU issue rd=0, and LU result rd=0. Required: no `RegWrite` pulse, `busy_mask` unchanged, `wb_stall`=0, `lu_ready`=1.
- **Wrap-around:** 6 back-to-back LU results to r10..r15 with WB idle, pushing and popping the same cycle. Required: writes in order r10..r15, one per cycle, FIFO count never exceeds 2, final count 0.
